// File: rtl/stopwatch_pkg.sv
// Shared types, seven-segment patterns and decode helper for the BCD stopwatch.
package stopwatch_pkg;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // gfedcba, 1 = lit; entry 10 is the dash shown for a non-BCD nibble.
  localparam logic [6:0] SEG_PATTERNS [11] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F, 7'h40
  };

  function automatic logic [6:0] seg_pattern(input bcd_t d);
    if (d <= 4'd9) begin
      return SEG_PATTERNS[int'(d)];
    end
    return SEG_PATTERNS[10];
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One decade of the BCD counter: counts 0..9 on inc and ripples a carry to the next decade.
module bcd_digit_cell
  import stopwatch_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic clr,
  input  logic inc,
  output bcd_t value,
  output logic carry
);

  bcd_t value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (clr) begin
      value_d = '0;
    end else if (inc) begin
      value_d = (value_q == 4'd9) ? 4'd0 : value_q + 4'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;
  assign carry = inc && (value_q == 4'd9);

endmodule

// File: rtl/bcd_stopwatch_core.sv
// Multi-digit BCD stopwatch with lap freeze and a multiplexed seven-segment scan driver.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
module bcd_stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned DIGITS    = 4,
  parameter int unsigned TICK_DIV  = 1200000,
  parameter int unsigned SCAN_LOG2 = 10,
  parameter int unsigned DP_DIGIT  = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  btn_clear,
  input  logic                  btn_start,
  input  logic                  btn_stop,
  input  logic                  btn_lap,
  output logic                  running,
  output logic                  lap_active,
  output logic                  wrap,
  output logic [4*DIGITS-1:0]   count_bcd,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = $clog2(DIGITS);

  logic [PW-1:0]        presc_q, presc_d;
  logic                 running_q, running_d;
  logic                 lap_active_q, lap_active_d;
  logic [4*DIGITS-1:0]  latch_q, latch_d;
  logic                 btn_lap_q;
  logic                 wrap_q;
  logic [SCAN_LOG2-1:0] scan_cnt_q;
  logic [IW-1:0]        idx_q, idx_next;
  logic [6:0]           seg_q, seg_next;
  logic                 dp_q, dp_next;
  logic [DIGITS-1:0]    digit_en_q, digit_en_next;

  logic                 tick;
  logic                 lap_edge;
  logic                 scan_pulse;
  logic [DIGITS:0]      carry;
  bcd_t                 digit_val [DIGITS];
  logic [4*DIGITS-1:0]  src;
  bcd_t                 src_digit;

  assign tick       = (presc_q == PW'(TICK_DIV - 1));
  assign lap_edge   = btn_lap && !btn_lap_q;
  assign scan_pulse = &scan_cnt_q;

  // Stop and clear both suppress a same-cycle tick.
  assign carry[0] = tick && running_q && !btn_clear && !btn_stop;

  for (genvar i = 0; i < int'(DIGITS); i++) begin : g_digit
    bcd_digit_cell u_cell (
      .CLK   (CLK),
      .RST   (RST),
      .clr   (btn_clear),
      .inc   (carry[i]),
      .value (digit_val[i]),
      .carry (carry[i+1])
    );
    assign count_bcd[4*i +: 4] = digit_val[i];
  end

  always_comb begin
    presc_d      = tick ? '0 : presc_q + PW'(1);
    running_d    = running_q;
    lap_active_d = lap_active_q;
    latch_d      = latch_q;
    if (btn_clear) begin
      presc_d      = '0;
      running_d    = 1'b0;
      lap_active_d = 1'b0;
    end else begin
      if (btn_stop) begin
        running_d = 1'b0;
      end else if (btn_start) begin
        running_d = 1'b1;
      end
      if (lap_edge) begin
        lap_active_d = !lap_active_q;
        if (!lap_active_q) begin
          latch_d = count_bcd;
        end
      end
    end
  end

  assign src      = lap_active_q ? latch_q : count_bcd;
  assign idx_next = (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + IW'(1);
  assign src_digit = src[4*idx_next +: 4];

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] lz_blank;
  logic              all_zero;

  // A digit blanks when it and every more-significant digit are zero; digit 0 never blanks.
  always_comb begin
    lz_blank = '0;
    all_zero = 1'b1;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      all_zero    = all_zero && (src[4*i +: 4] == 4'd0);
      lz_blank[i] = all_zero;
    end
  end
`endif

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    seg_next = lz_blank[idx_next] ? SEG_BLANK : ~seg_pattern(src_digit);
`else
    seg_next = ~seg_pattern(src_digit);
`endif
    digit_en_next = DIGITS'(1) << idx_next;
    dp_next       = (32'(idx_next) == DP_DIGIT) ? 1'b0 : 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_q      <= '0;
      running_q    <= 1'b0;
      lap_active_q <= 1'b0;
      latch_q      <= '0;
      btn_lap_q    <= 1'b0;
      wrap_q       <= 1'b0;
      scan_cnt_q   <= '0;
      idx_q        <= '0;
      seg_q        <= SEG_BLANK;
      dp_q         <= 1'b1;
      digit_en_q   <= '0;
    end else begin
      presc_q      <= presc_d;
      running_q    <= running_d;
      lap_active_q <= lap_active_d;
      latch_q      <= latch_d;
      btn_lap_q    <= btn_lap;
      wrap_q       <= carry[DIGITS];
      scan_cnt_q   <= scan_cnt_q + SCAN_LOG2'(1);
      if (scan_pulse) begin
        idx_q      <= idx_next;
        seg_q      <= seg_next;
        dp_q       <= dp_next;
        digit_en_q <= digit_en_next;
      end
    end
  end

  assign running    = running_q;
  assign lap_active = lap_active_q;
  assign wrap       = wrap_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign digit_en   = digit_en_q;

endmodule
